// File: rtl/c4_pkg.sv
// Shared Connect-4 board constants, piece codes and direction/state types.
// Imported by the win checker FSM and its coordinate stepper.
package c4_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int WIN_LEN = 4;

  typedef logic [1:0] piece_t;

  localparam piece_t EMPTY = 2'b00;
  localparam piece_t P1    = 2'b01;
  localparam piece_t P2    = 2'b10;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D,
    DIR_A
  } dir_e;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_POS,
    SCAN_NEG,
    NEXT_DIR,
    DONE
  } state_e;

endpackage

// File: rtl/c4_dir_step.sv
// Stepped board coordinate (last +/- step*d) with on-board flag.
// 4-bit signed math: anything past 7 wraps negative, so bit 3 flags off-board.
module c4_dir_step
  import c4_pkg::*;
(
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  dir_e       dir,
  input  logic [1:0] step,
  input  logic       sign,
  output logic [2:0] out_row,
  output logic [2:0] out_col,
  output logic       on_board
);

  logic signed [3:0] s;
  logic signed [3:0] dr;
  logic signed [3:0] dc;
  logic signed [3:0] r;
  logic signed [3:0] c;

  assign s = sign ? -$signed({2'b00, step})
                  :  $signed({2'b00, step});

  always_comb begin
    dr = 4'sd0;
    dc = 4'sd0;
    unique case (1'b1)
      dir == DIR_H: dc = 4'sd1;
      dir == DIR_V: dr = 4'sd1;
      dir == DIR_D: begin
        dr = 4'sd1;
        dc = 4'sd1;
      end
      dir == DIR_A: begin
        dr = 4'sd1;
        dc = -4'sd1;
      end
    endcase
  end

  assign r = $signed({1'b0, row}) + s * dr;
  assign c = $signed({1'b0, col}) + s * dc;

  assign out_row  = r[2:0];
  assign out_col  = c[2:0];
  assign on_board = ~r[3] & ~c[3];

endmodule

// File: rtl/win_checker.sv
// Connect-4 win detector: scans the four lines through the last piece,
// one board read per cycle, and reports win with a one-cycle done pulse.
module win_checker
  import c4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] last_row,
  input  logic [2:0] last_col,
  input  logic [1:0] player,
  output logic       rd_en,
  output logic [2:0] rd_row,
  output logic [2:0] rd_col,
  input  logic [1:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       win
);

  state_e     state;
  dir_e       dir;
  logic [2:0] run;
  logic [1:0] step;
  logic [2:0] lrow;
  logic [2:0] lcol;
  piece_t     lply;

  logic [2:0] srow;
  logic [2:0] scol;
  logic       on_board;
  logic       scan;
  logic       hit;
  logic [2:0] run_inc;
  logic       valid;

  c4_dir_step u_step (
    .row      (lrow),
    .col      (lcol),
    .dir      (dir),
    .step     (step),
    .sign     (state == SCAN_NEG),
    .out_row  (srow),
    .out_col  (scol),
    .on_board (on_board)
  );

  assign scan    = (state == SCAN_POS) || (state == SCAN_NEG);
  assign rd_en   = scan && on_board;
  assign rd_row  = rd_en ? srow : 3'd0;
  assign rd_col  = rd_en ? scol : 3'd0;
  assign hit     = rd_en && (rd_data == lply);
  assign run_inc = (run >= 3'(WIN_LEN)) ? 3'(WIN_LEN) : run + 3'd1;
  assign valid   = (player == P1) || (player == P2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dir   <= DIR_H;
      run   <= 3'd0;
      step  <= 2'd0;
      lrow  <= 3'd0;
      lcol  <= 3'd0;
      lply  <= EMPTY;
      busy  <= 1'b0;
      done  <= 1'b0;
      win   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            win  <= 1'b0;
            busy <= 1'b1;
            if (valid) begin
              lrow  <= last_row;
              lcol  <= last_col;
              lply  <= player;
              run   <= 3'd1;
              step  <= 2'd1;
              dir   <= DIR_H;
              state <= SCAN_POS;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        SCAN_POS, SCAN_NEG: begin
          if (hit && run_inc == 3'(WIN_LEN)) begin
            run   <= run_inc;
            win   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (hit && step != 2'd3) begin
            run  <= run_inc;
            step <= step + 2'd1;
          end else begin
            if (hit) run <= run_inc;
            step  <= 2'd1;
            state <= (state == SCAN_POS) ? SCAN_NEG : NEXT_DIR;
          end
        end
        NEXT_DIR: begin
          run  <= 3'd1;
          step <= 2'd1;
          if (dir == DIR_A) begin
            win   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            dir   <= dir_e'(2'(dir + 2'd1));
            state <= SCAN_POS;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_win_checker.sv
// Directed bench for win_checker: board model, expected-result scoreboard,
// read logging and reset-abort scenario.
module tb_win_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] last_row = 3'd0;
  logic [2:0] last_col = 3'd0;
  logic [1:0] player = 2'b00;
  logic       rd_en;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [1:0] rd_data;
  logic       busy;
  logic       done;
  logic       win;

  typedef struct {
    string tag;
    logic  win;
    int    reads;
    int    cycles;
  } exp_t;

  exp_t        sb[$];
  logic [5:0]  rlog[$];
  logic [1:0]  board [8][8];
  int          n_cmp = 0;
  int          n_err = 0;
  int          nreads = 0;

  win_checker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .last_row (last_row),
    .last_col (last_col),
    .player   (player),
    .rd_en    (rd_en),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .win      (win)
  );

  always #5 clk = ~clk;

  assign rd_data = board[rd_row][rd_col];

  always @(negedge clk) begin
    if (rd_en) begin
      nreads++;
      rlog.push_back({rd_row, rd_col});
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        board[r][c] = 2'b00;
  endtask

  task automatic run_case(input string tag, input logic [2:0] r,
                          input logic [2:0] c, input logic [1:0] p,
                          input logic ew, input int er, input int ec);
    exp_t e;
    int   cyc;
    sb.push_back('{tag, ew, er, ec});
    @(negedge clk);
    nreads = 0;
    rlog.delete();
    start = 1'b1;
    last_row = r;
    last_col = c;
    player = p;
    @(negedge clk);
    start = 1'b0;
    last_row = 3'd0;
    last_col = 3'd0;
    player = 2'b00;
    cyc = 1;
    check({tag, "_busy"}, int'(busy), 1);
    while (!done && cyc < 40) begin
      start = (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_done"}, int'(done), 1);
    check({e.tag, "_win"}, int'(win), int'(e.win));
    check({e.tag, "_reads"}, nreads, e.reads);
    check({e.tag, "_cycles"}, cyc, e.cycles);
    @(negedge clk);
    check({e.tag, "_done_1cyc"}, int'(done), 0);
    check({e.tag, "_idle_busy"}, int'(busy), 0);
    check({e.tag, "_win_held"}, int'(win), int'(e.win));
  endtask

  initial begin
    logic [5:0] exp_log [4];
    clear_board();
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_win", int'(win), 0);
    check("rst_rd_en", int'(rd_en), 0);
    rst_n = 1'b1;

    // horizontal P1 at row 0 cols 0-3, last piece at the end
    for (int c = 0; c < 4; c++) board[0][c] = 2'b01;
    run_case("horiz", 3'd0, 3'd3, 2'b01, 1'b1, 4, 5);
    exp_log = '{6'o04, 6'o02, 6'o01, 6'o00};
    check("horiz_nlog", rlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rlog.size())
        check($sformatf("horiz_addr%0d", i), int'(rlog[i]), int'(exp_log[i]));

    // vertical P2 stack, col 5
    clear_board();
    for (int r = 0; r < 4; r++) board[r][5] = 2'b10;
    run_case("vert", 3'd3, 3'd5, 2'b10, 1'b1, 6, 8);
    foreach (rlog[i])
      if (i >= 3) check($sformatf("vert_row%0d", i), int'(rlog[i][5:3]) < 3 ? 1 : 0, 1);

    // isolated corner piece
    clear_board();
    board[7][7] = 2'b01;
    run_case("corner", 3'd7, 3'd7, 2'b01, 1'b0, 3, 13);

    // anti-diagonal
    clear_board();
    board[3][0] = 2'b01;
    board[2][1] = 2'b01;
    board[1][2] = 2'b01;
    board[0][3] = 2'b01;
    run_case("anti", 3'd1, 3'd2, 2'b01, 1'b1, 9, 14);

    // three P2 in a row blocked by a P1: no win
    clear_board();
    board[0][0] = 2'b10;
    board[0][1] = 2'b10;
    board[0][2] = 2'b10;
    board[0][3] = 2'b01;
    run_case("three", 3'd0, 3'd1, 2'b10, 1'b0, 6, 15);

    // invalid player codes
    run_case("inv00", 3'd0, 3'd1, 2'b00, 1'b0, 0, 1);
    run_case("inv11", 3'd0, 3'd1, 2'b11, 1'b0, 0, 1);

    // reset in the middle of a scan
    clear_board();
    board[7][7] = 2'b01;
    @(negedge clk);
    start = 1'b1;
    last_row = 3'd7;
    last_col = 3'd7;
    player = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rd_en", int'(rd_en), 1);
    check("mid_rd_row", int'(rd_row), 6);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_win", int'(win), 0);
    check("abort_rd_en", int'(rd_en), 0);
    check("abort_rd_row", int'(rd_row), 0);
    check("abort_rd_col", int'(rd_col), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_nodone%0d", i), int'(done), 0);
    end
    rst_n = 1'b1;

    clear_board();
    for (int c = 0; c < 4; c++) board[0][c] = 2'b01;
    run_case("post_rst", 3'd0, 3'd3, 2'b01, 1'b1, 4, 5);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
